sockit_ffo_chk: RTL and testbench

//  Synthesizable sink/checker for the output (ffo) side of the req/grt stream used by sockit_cdc.

---
 rtl/sockit_pkg.sv | 18 +
 rtl/sockit_lfsr32.sv | 21 ++
 rtl/sockit_ffo_chk.sv | 122 ++++++++++++
 tb/tb_sockit_ffo_chk.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sockit_pkg.sv
// Shared types and LFSR step for the sockit stream generator/checker pair.
// Used by sockit_lfsr32 and sockit_ffo_chk.
package sockit_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

  // Galois right-shift form: feed the dropped bit back through the taps
  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    return (s >> 1) ^ (s[0] ? LFSR_TAPS : 32'h0);
  endfunction

endpackage

// File: rtl/sockit_lfsr32.sv
// 32-bit Galois LFSR with load-on-reset seed and step enable.
// Shared by the ffo-side checker and the ffi-side generator.
module sockit_lfsr32
  import sockit_pkg::*;
(
  input  logic        ffo_clk,
  input  logic        ffo_rst,
  input  logic        en,
  input  logic [31:0] seed,
  output logic [31:0] out
);

  always_ff @(posedge ffo_clk) begin
    if (!ffo_rst) begin
      out <= seed;
    end else if (en) begin
      out <= lfsr_next(out);
    end
  end

endmodule

// File: rtl/sockit_ffo_chk.sv
// Stream sink with random grant and incrementing-sequence checker.
// SOCKIT_CHK_CAPTURE_EN adds first-mismatch capture ports sts_fev/sts_fex.
module sockit_ffo_chk
  import sockit_pkg::*;
#(
  parameter int          DW   = 8,
  parameter int          LW   = 16,
  parameter int          EW   = 8,
  parameter logic [31:0] SEED = 32'h1
) (
  input  logic          ffo_clk,
  input  logic          ffo_rst,
  input  logic          cfg_run,
  input  logic [31:0]   cfg_prb,
  input  logic [LW-1:0] cfg_len,
  input  logic [DW-1:0] cfg_ini,
  input  logic [DW-1:0] ffo_bus,
  input  logic          ffo_req,
  output logic          ffo_grt,
  output logic [LW-1:0] sts_cnt,
  output logic [EW-1:0] sts_err,
  output logic          sts_done
`ifdef SOCKIT_CHK_CAPTURE_EN
  ,
  output logic [DW-1:0] sts_fev,
  output logic [DW-1:0] sts_fex
`endif
);

  state_t        state;
  logic [DW-1:0] exp_q;
  logic [LW-1:0] len_q;
  logic [31:0]   lfsr;
  logic          trn;
  logic          lfsr_lt;
  logic          mis;
  logic          last;
  logic [LW-1:0] cnt_nx;

  sockit_lfsr32 u_lfsr (
    .ffo_clk (ffo_clk),
    .ffo_rst (ffo_rst),
    .en      (state == RUN),
    .seed    (SEED),
    .out     (lfsr)
  );

  assign trn     = ffo_req & ffo_grt;
  assign lfsr_lt = lfsr < cfg_prb;
  assign mis     = ffo_bus != exp_q;
  assign cnt_nx  = sts_cnt + LW'(1);
  assign last    = cnt_nx == len_q;

  always_ff @(posedge ffo_clk) begin
    if (!ffo_rst) begin
      state    <= IDLE;
      ffo_grt  <= 1'b0;
      sts_cnt  <= '0;
      sts_err  <= '0;
      sts_done <= 1'b0;
      exp_q    <= '0;
      len_q    <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (cfg_run) begin
            exp_q    <= cfg_ini;
            len_q    <= cfg_len;
            sts_cnt  <= '0;
            sts_err  <= '0;
            sts_done <= cfg_len == '0;
            state    <= (cfg_len == '0) ? DONE : RUN;
          end
        end
        RUN: begin
          if (!cfg_run) begin
            state   <= IDLE;
            ffo_grt <= 1'b0;
          end else begin
            // a raised grant is held until the source takes it
            ffo_grt <= (~ffo_grt | trn) ? lfsr_lt : 1'b1;
            if (trn) begin
              sts_cnt <= cnt_nx;
              exp_q   <= exp_q + DW'(1);
              if (mis && sts_err != {EW{1'b1}}) begin
                sts_err <= sts_err + EW'(1);
              end
              if (last) begin
                state    <= DONE;
                sts_done <= 1'b1;
                ffo_grt  <= 1'b0;
              end
            end
          end
        end
        DONE: begin
          if (!cfg_run) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SOCKIT_CHK_CAPTURE_EN
  // sts_err still zero means this is the first mismatch of the run
  always_ff @(posedge ffo_clk) begin
    if (!ffo_rst) begin
      sts_fev <= '0;
      sts_fex <= '0;
    end else if (state == IDLE && cfg_run) begin
      sts_fev <= '0;
      sts_fex <= '0;
    end else if (state == RUN && cfg_run && trn && mis && sts_err == '0) begin
      sts_fev <= ffo_bus;
      sts_fex <= exp_q;
    end
  end
`endif

endmodule

// File: tb/tb_sockit_ffo_chk.sv
// Scoreboard bench for sockit_ffo_chk, default and EW=2 instances in lockstep.
// Honours SOCKIT_CHK_CAPTURE_EN for the capture ports.
module tb_sockit_ffo_chk;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        run = 1'b0;
  logic        req = 1'b0;
  logic [31:0] prb = 32'hffff_ffff;
  logic [15:0] len = '0;
  logic [7:0]  ini = '0;
  logic [7:0]  bus = '0;

  logic        grt, grt_e, done, done_e;
  logic [15:0] cnt, cnt_e;
  logic [7:0]  err;
  logic [1:0]  err_e;
`ifdef SOCKIT_CHK_CAPTURE_EN
  logic [7:0]  fev, fex, fev_e, fex_e;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct {
    int cnt;
    int err;
    int err2;
  } exp_t;
  exp_t q[$];

  int         mcnt, merr, merr2;
  logic [7:0] mexp;

  always #5 clk = ~clk;

  sockit_ffo_chk dut (
    .ffo_clk  (clk),
    .ffo_rst  (rst),
    .cfg_run  (run),
    .cfg_prb  (prb),
    .cfg_len  (len),
    .cfg_ini  (ini),
    .ffo_bus  (bus),
    .ffo_req  (req),
    .ffo_grt  (grt),
    .sts_cnt  (cnt),
    .sts_err  (err),
    .sts_done (done)
`ifdef SOCKIT_CHK_CAPTURE_EN
    ,
    .sts_fev  (fev),
    .sts_fex  (fex)
`endif
  );

  sockit_ffo_chk #(.EW(2)) dut_e (
    .ffo_clk  (clk),
    .ffo_rst  (rst),
    .cfg_run  (run),
    .cfg_prb  (prb),
    .cfg_len  (len),
    .cfg_ini  (ini),
    .ffo_bus  (bus),
    .ffo_req  (req),
    .ffo_grt  (grt_e),
    .sts_cnt  (cnt_e),
    .sts_err  (err_e),
    .sts_done (done_e)
`ifdef SOCKIT_CHK_CAPTURE_EN
    ,
    .sts_fev  (fev_e),
    .sts_fex  (fex_e)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s got %0h want %0h at %0t", name, act, want, $time);
    end
  endtask

  always @(posedge clk) begin
    bit   t, hold;
    exp_t e;
    t    = req && grt && rst;
    hold = grt && !req && rst && run;
    #1;
    if (t) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexp_trn cnt %0d with empty scoreboard", cnt);
      end else begin
        e = q.pop_front();
        chk("mon_cnt", 32'(cnt), e.cnt);
        chk("mon_err", 32'(err), e.err);
        chk("mon_err_e", 32'(err_e), e.err2);
      end
    end
    if (hold) chk("grt_hold", 32'(grt), 1);
  end

  task automatic xfer(input logic [7:0] d, input int gap);
    int n;
    bit fin;
    repeat (gap) begin
      req = 1'b0;
      bus = 8'($urandom);
      @(negedge clk);
    end
    req = 1'b1;
    bus = d;
    n   = 0;
    fin = 0;
    while (!fin) begin
      if (grt) begin
        mcnt++;
        if (d !== mexp) begin
          if (merr < 255) merr++;
          if (merr2 < 3) merr2++;
        end
        mexp++;
        q.push_back('{mcnt, merr, merr2});
        @(negedge clk);
        fin = 1;
      end else begin
        @(negedge clk);
        n++;
        if (n > 300) begin
          checks++;
          errors++;
          $display("FAIL grant_timeout data %0h", d);
          fin = 1;
        end
      end
    end
    req = 1'b0;
  endtask

  task automatic start_run(input logic [7:0] i, input logic [15:0] l);
    ini   = i;
    len   = l;
    run   = 1'b1;
    mexp  = i;
    mcnt  = 0;
    merr  = 0;
    merr2 = 0;
    @(negedge clk);
    chk("start_cnt", 32'(cnt), 0);
    chk("start_err", 32'(err), 0);
    chk("start_done", 32'(done), 32'(l == 0));
    chk("start_grt", 32'(grt), 0);
  endtask

  task automatic end_run(input int c, input int e, input int e2);
    chk("end_cnt", 32'(cnt), c);
    chk("end_err", 32'(err), e);
    chk("end_err_e", 32'(err_e), e2);
    chk("end_done", 32'(done), 1);
    chk("end_grt", 32'(grt), 0);
    run = 1'b0;
    @(negedge clk);
    chk("idle_done_kept", 32'(done), 1);
    chk("idle_cnt_kept", 32'(cnt), c);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_grt", 32'(grt), 0);
    chk("rst_cnt", 32'(cnt), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_done", 32'(done), 0);
    rst = 1'b1;
    @(negedge clk);

    // 1: full-rate run of 64
    start_run(8'h00, 16'd64);
    for (int i = 0; i < 64; i++) xfer(8'(i), 0);
    end_run(64, 0, 0);

    // 2: sequence wraps through 8'hff
    start_run(8'hfa, 16'd10);
    for (int i = 0; i < 10; i++) xfer(8'(8'hfa + i), 0);
    end_run(10, 0, 0);

    // 3: one bad word
    start_run(8'h00, 16'd64);
    for (int i = 0; i < 64; i++) xfer((i == 5) ? 8'h55 : 8'(i), 0);
`ifdef SOCKIT_CHK_CAPTURE_EN
    chk("cap_fev", 32'(fev), 32'h55);
    chk("cap_fex", 32'(fex), 32'h05);
`endif
    end_run(64, 1, 1);

    // 4: half-rate grant with random request gaps
    prb = 32'h7fff_ffff;
    start_run(8'h00, 16'd64);
    for (int i = 0; i < 64; i++) xfer(8'(i), int'($urandom_range(0, 3)));
    end_run(64, 0, 0);
    prb = 32'hffff_ffff;

    // 5a: zero length goes straight to done
    start_run(8'h00, 16'd0);
    repeat (3) begin
      req = 1'b1;
      @(negedge clk);
      chk("len0_grt", 32'(grt), 0);
      chk("len0_cnt", 32'(cnt), 0);
    end
    req = 1'b0;
    end_run(0, 0, 0);

    // 5b: five bad words saturate the 2-bit counter
    start_run(8'h00, 16'd8);
    xfer(8'h00, 0);
    for (int i = 0; i < 5; i++) xfer(8'h09, 0);
    xfer(8'h06, 0);
    xfer(8'h07, 0);
`ifdef SOCKIT_CHK_CAPTURE_EN
    chk("cap_fev_b", 32'(fev), 32'h09);
    chk("cap_fex_b", 32'(fex), 32'h01);
`endif
    end_run(8, 5, 3);

    // 6: reset at transfer 20, restart, then abort
    start_run(8'h10, 16'd64);
    for (int i = 0; i < 19; i++) xfer(8'(8'h10 + i), 0);
    req = 1'b1;
    bus = 8'h23;
    rst = 1'b0;
    @(negedge clk);
    req = 1'b0;
    chk("mrst_grt", 32'(grt), 0);
    chk("mrst_cnt", 32'(cnt), 0);
    chk("mrst_err", 32'(err), 0);
    chk("mrst_done", 32'(done), 0);
    chk("mrst_grt_e", 32'(grt_e), 0);
    rst = 1'b1;
    start_run(8'h10, 16'd64);
    for (int i = 0; i < 64; i++) xfer(8'(8'h10 + i), 0);
    end_run(64, 0, 0);

    start_run(8'h00, 16'd64);
    for (int i = 0; i < 10; i++) xfer(8'(i), 0);
    run = 1'b0;
    @(negedge clk);
    chk("abort_grt", 32'(grt), 0);
    chk("abort_cnt", 32'(cnt), 10);
    chk("abort_done", 32'(done), 0);
    req = 1'b1;
    repeat (2) @(negedge clk);
    chk("abort_idle_grt", 32'(grt), 0);
    chk("abort_idle_cnt", 32'(cnt), 10);
    req = 1'b0;

    repeat (3) @(negedge clk);
    chk("sb_empty", 32'(q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
